uart_rx_deframer: RTL and testbench
===================================

# uart_rx_deframer

Downstream stage of the UART receiver: consumes each received byte and its save strobe, hunts for the 0xEB 0x90 sync word, reads a length byte and payload, and checks an XOR checksum. Payload bytes go into an internal FIFO speculatively and become visible to the reader only when the frame's checksum passes. Bad frames are rewound out of the buffer. The FIFO is read first-word-fall-through by the command/telemetry logic.

## Interface
Parameters:
- ADDR_W, 6: FIFO address width; DEPTH = 2^ADDR_W = 64 bytes
- MAX_LEN, 32: largest legal payload length (1..DEPTH)
- SYNC1, 8'hEB: first sync byte
- SYNC2, 8'h90: second sync byte

Ports:
- i_Clock  in  1  system clock
- RESET  in  1  asynchronous, active-low reset
- EN  in  1  enable; when low, strobes are ignored and state is held
- i_RX_Byte  in  8  received byte, stable while i_save_byte is high
- i_save_byte  in  1  save strobe, held high for several cycles per byte
- i_rd_en  in  1  pop one committed byte
- o_rd_data  out  8  committed byte at the read pointer (FWFT)
- o_empty  out  1  no committed bytes
- o_count  out  ADDR_W+1  committed byte count
- o_frame_done  out  1  1-cycle pulse: frame committed
- o_frame_err  out  1  1-cycle pulse: frame discarded
- o_err_code  out  2  01 checksum, 10 length, 11 overflow; holds last error
- o_frame_count  out  16  good frames since reset, wraps at 0xFFFF→0
- o_state  out  3  current state

## Operation
- Byte acceptance:
  - save_d registers i_save_byte; it updates only while EN=1.
  - accept = EN & i_save_byte & ~save_d. Exactly one accept per strobe, regardless of strobe length.
- States: HUNT1=0, HUNT2=1, LEN=2, PAYLOAD=3, CHK=4. Codes 5–7 go to HUNT1.
- HUNT1: accepted byte == SYNC1 → HUNT2.
- HUNT2:
  - SYNC2 → LEN.
  - SYNC1 → stay in HUNT2.
  - Any other byte → HUNT1.
- LEN:
  - Latch len and set chk = byte.
  - len > MAX_LEN → err code 10, pulse o_frame_err, go to HUNT1.
  - len == 0 → CHK.
  - Otherwise → PAYLOAD with remaining = len.
- PAYLOAD:
  - If speculative full (wr_spec − rd_ptr == DEPTH): rewind wr_spec to wr_commit, err code 11, pulse o_frame_err, go to HUNT1. The byte is dropped.
  - Otherwise write mem[wr_spec], increment wr_spec, chk ^= byte, decrement remaining. When remaining reaches 0 → CHK.
- CHK:
  - byte == chk → wr_commit = wr_spec, pulse o_frame_done, increment o_frame_count.
  - byte != chk → wr_spec = wr_commit, err code 01, pulse o_frame_err.
  - Either way → HUNT1.
- Reader side:
  - o_count = wr_commit − rd_ptr (ADDR_W+1-bit pointers, mod 2^(ADDR_W+1)).
  - o_empty = (o_count == 0).
  - o_rd_data = mem[rd_ptr[ADDR_W-1:0]].
  - i_rd_en with o_empty=1 is ignored.
- Pointer arithmetic: all pointers are ADDR_W+1 bits and wrap naturally. Full and empty are distinguished by the MSB.
- EN low: state, pointers and save_d are held; reads still operate.

## Timing
- Reset (RESET=0, asynchronous):
  - State HUNT1; all pointers, chk, len and save_d = 0.
  - o_frame_done = 0, o_frame_err = 0, o_err_code = 00, o_frame_count = 0, o_count = 0, o_empty = 1.
  - o_rd_data is undefined; memory is not cleared.
- Accept is seen in the cycle after the strobe's rising edge is registered. State, pointer and pulse updates appear one edge after the accept cycle.
- o_frame_done / o_frame_err are high exactly one cycle, on the edge following the accept of the CHK byte (or the error byte).
- A committed frame is readable (o_empty falls) in the same cycle o_frame_done is high.
- Read: o_rd_data is valid while o_empty=0. rd_ptr advances on the edge where i_rd_en=1. The next byte appears the following cycle.
- Simultaneous commit and read in one cycle: both take effect; o_count = old + committed − 1.
- Full uses the speculative pointer, so reading during PAYLOAD frees space immediately.
- Reset mid-frame discards all buffered data, committed or not.

## Test plan
- Good frame: strobes EB 90 03 11 22 33 and chk 03^11^22^33 = 0x03 → o_frame_done pulses once, o_count = 3, reads return 11, 22, 33, then o_empty = 1, o_frame_count = 1.
- Bad checksum: EB 90 02 AA 55 00 → o_frame_err pulses, o_err_code = 01, o_count stays 0. A following good frame commits normally.
- Sync slip and length: EB EB 90 00 00 → zero-length frame commits with o_count unchanged. EB 90 21 (MAX_LEN = 32) → o_err_code = 10, state returns to HUNT1.
- Overflow: commit two 32-byte frames with no reads, then a third frame's first payload byte → o_err_code = 11, o_count stays 64. Read one byte, then send the frame again → it still fails on its second byte. Read all 64 bytes, then send the frame → it commits.
- Strobe handling: i_save_byte held for 7 cycles per byte → each byte is accepted exactly once. With EN = 0 during a strobe, that byte is ignored.
- Async reset asserted mid-PAYLOAD and between clock edges → all outputs are at reset values immediately. After release, a new frame decodes correctly.

Source files
------------

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: sync-word frame parser with checksum-gated FWFT byte FIFO
// Ports:
//   i_Clock, RESET (async active-low), EN (hold everything except reads)
//   i_RX_Byte / i_save_byte : byte and its (multi-cycle) save strobe
//   i_rd_en / o_rd_data / o_empty / o_count : FWFT reader of committed bytes
//   o_frame_done / o_frame_err : one-cycle frame outcome pulses
//   o_err_code : last error (01 checksum, 10 length, 11 overflow)
//   o_frame_count : good frames since reset; o_state : parser state
module uart_rx_deframer #(
  parameter int ADDR_W = 6,
  parameter int MAX_LEN = 32,
  parameter logic [7:0] SYNC1 = 8'hEB,
  parameter logic [7:0] SYNC2 = 8'h90
) (
  input  logic              i_Clock,
  input  logic              RESET,
  input  logic              EN,
  input  logic [7:0]        i_RX_Byte,
  input  logic              i_save_byte,
  input  logic              i_rd_en,
  output logic [7:0]        o_rd_data,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_count,
  output logic              o_frame_done,
  output logic              o_frame_err,
  output logic [1:0]        o_err_code,
  output logic [15:0]       o_frame_count,
  output logic [2:0]        o_state
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [7:0] MAX_L = 8'(MAX_LEN);
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
  typedef enum logic [2:0] {HUNT1 = 3'd0, HUNT2 = 3'd1, LEN = 3'd2, PAYLOAD = 3'd3, CHK = 3'd4} state_t;
  state_t r_state, w_next;
  logic [7:0] r_mem [DEPTH];
  logic [ADDR_W:0] r_wr_spec, r_wr_commit, r_rd_ptr, w_fill;
  logic [7:0] r_chk, r_rem;
  logic [15:0] r_fcnt;
  logic [1:0] r_code, w_code;
  logic r_save_d, r_done, r_err;
  logic w_accept, w_full, w_wr, w_ok, w_bad, w_rd;
  assign w_accept = EN & i_save_byte & ~r_save_d;
  // full is judged on the speculative pointer so uncommitted bytes count
  assign w_fill = r_wr_spec - r_rd_ptr;
  assign w_full = w_fill == FULL;
  assign o_count = r_wr_commit - r_rd_ptr;
  assign o_empty = o_count == '0;
  assign w_rd = i_rd_en & ~o_empty;
  assign o_rd_data = r_mem[r_rd_ptr[ADDR_W-1:0]];
  assign o_frame_done = r_done;
  assign o_frame_err = r_err;
  assign o_err_code = r_code;
  assign o_frame_count = r_fcnt;
  assign o_state = r_state;
  always_comb begin
    w_next = r_state;
    w_wr = 1'b0;
    w_ok = 1'b0;
    w_bad = 1'b0;
    w_code = r_code;
    case (r_state)
      HUNT1: if (w_accept && i_RX_Byte == SYNC1) w_next = HUNT2;
      HUNT2: if (w_accept) w_next = i_RX_Byte == SYNC2 ? LEN : i_RX_Byte == SYNC1 ? HUNT2 : HUNT1;
      LEN: if (w_accept) begin
        w_next = i_RX_Byte > MAX_L ? HUNT1 : i_RX_Byte == 8'd0 ? CHK : PAYLOAD;
        w_bad = i_RX_Byte > MAX_L;
        w_code = w_bad ? 2'b10 : r_code;
      end
      PAYLOAD: if (w_accept) begin
        w_wr = ~w_full;
        w_bad = w_full;
        w_code = w_full ? 2'b11 : r_code;
        w_next = w_full ? HUNT1 : r_rem == 8'd1 ? CHK : PAYLOAD;
      end
      CHK: if (w_accept) begin
        w_next = HUNT1;
        w_ok = i_RX_Byte == r_chk;
        w_bad = ~w_ok;
        w_code = w_ok ? r_code : 2'b01;
      end
      default: w_next = HUNT1;
    endcase
  end
  always_ff @(posedge i_Clock or negedge RESET) begin
    if (!RESET) begin
      r_state <= HUNT1;
      r_wr_spec <= '0;
      r_wr_commit <= '0;
      r_rd_ptr <= '0;
      r_chk <= '0;
      r_rem <= '0;
      r_fcnt <= '0;
      r_code <= '0;
      r_save_d <= 1'b0;
      r_done <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done <= w_ok;
      r_err <= w_bad;
      r_code <= w_code;
      if (EN) r_save_d <= i_save_byte;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_accept && r_state == LEN) begin
        r_chk <= i_RX_Byte;
        r_rem <= i_RX_Byte;
      end
      if (w_wr) begin
        r_wr_spec <= r_wr_spec + 1'b1;
        r_chk <= r_chk ^ i_RX_Byte;
        r_rem <= r_rem - 8'd1;
      end
      if (w_ok) begin
        r_wr_commit <= r_wr_spec;
        r_fcnt <= r_fcnt + 16'd1;
      end
      if (w_bad) r_wr_spec <= r_wr_commit;
    end
  end
  always_ff @(posedge i_Clock) if (w_wr) r_mem[r_wr_spec[ADDR_W-1:0]] <= i_RX_Byte;
endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb_uart_rx_deframer: randomized frames scored against a frame-level model
module tb_uart_rx_deframer;
  logic i_Clock = 1'b0, RESET = 1'b0, EN = 1'b1;
  logic [7:0] i_RX_Byte = 8'h00;
  logic i_save_byte = 1'b0, i_rd_en = 1'b0;
  logic [7:0] o_rd_data;
  logic o_empty, o_frame_done, o_frame_err;
  logic [6:0] o_count;
  logic [1:0] o_err_code;
  logic [15:0] o_frame_count;
  logic [2:0] o_state;
  uart_rx_deframer dut (
    .i_Clock(i_Clock), .RESET(RESET), .EN(EN), .i_RX_Byte(i_RX_Byte),
    .i_save_byte(i_save_byte), .i_rd_en(i_rd_en), .o_rd_data(o_rd_data),
    .o_empty(o_empty), .o_count(o_count), .o_frame_done(o_frame_done),
    .o_frame_err(o_frame_err), .o_err_code(o_err_code),
    .o_frame_count(o_frame_count), .o_state(o_state)
  );
  always #5 i_Clock = ~i_Clock;
  typedef struct {bit ok; logic [1:0] code; int len;} ev_t;
  ev_t evq[$];
  logic [7:0] pay_q[$], data_q[$], fp[$];
  logic [15:0] exp_fc = '0;
  int n_cmp = 0, n_err = 0, mcount = 0, hold_fix = 0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", n, act, exp, $time);
    end
  endtask
  ev_t ev;
  always @(negedge i_Clock) if (RESET) begin
    if (o_frame_done || o_frame_err) begin
      if (evq.size() == 0) chk("unexpected_pulse", {o_frame_done, o_frame_err}, 2'b00);
      else begin
        ev = evq.pop_front();
        chk("pulse_kind", {o_frame_done, o_frame_err}, ev.ok ? 2'b10 : 2'b01);
        if (ev.ok) begin
          for (int i = 0; i < ev.len; i++) data_q.push_back(pay_q.pop_front());
          exp_fc++;
          chk("frame_count", o_frame_count, exp_fc);
        end else chk("err_code", o_err_code, ev.code);
      end
    end
    chk("count", o_count, data_q.size());
    chk("empty", o_empty, data_q.size() == 0);
    if (i_rd_en && !o_empty && data_q.size() > 0) chk("rd_data", o_rd_data, data_q.pop_front());
  end
  task automatic step(input int n);
    repeat (n) begin @(posedge i_Clock); #1; end
  endtask
  task automatic send(input logic [7:0] b);
    int h = hold_fix != 0 ? hold_fix : $urandom_range(1, 7);
    i_RX_Byte = b;
    i_save_byte = 1'b1;
    step(h);
    i_save_byte = 1'b0;
    step(1 + $urandom_range(0, 2));
  endtask
  task automatic rd(input int n);
    i_rd_en = 1'b1;
    step(n);
    i_rd_en = 1'b0;
    mcount -= n;
  endtask
  task automatic preamble(input int pre, input bit xeb);
    logic [7:0] b;
    for (int i = 0; i < pre; i++) begin
      b = 8'($urandom_range(0, 255));
      send(b == 8'hEB ? 8'h00 : b);
    end
    if (xeb) send(8'hEB);
    send(8'hEB);
    send(8'h90);
  endtask
  // Sends the frame whose payload is in fp; the outcome is predicted from
  // the committed occupancy and whether the checksum byte is correct.
  task automatic frame(input bit good, input int pre, input bit xeb);
    logic [7:0] c = 8'(fp.size());
    int room = 64 - mcount;
    foreach (fp[i]) c ^= fp[i];
    preamble(pre, xeb);
    if (fp.size() > room) begin
      evq.push_back('{1'b0, 2'b11, 0});
      send(8'(fp.size()));
      for (int i = 0; i <= room; i++) send(fp[i]);
    end else begin
      if (good) begin
        evq.push_back('{1'b1, 2'b00, fp.size()});
        foreach (fp[i]) pay_q.push_back(fp[i]);
        mcount += fp.size();
      end else evq.push_back('{1'b0, 2'b01, 0});
      send(8'(fp.size()));
      foreach (fp[i]) send(fp[i]);
      send(good ? c : c ^ 8'($urandom_range(1, 255)));
    end
    step(3);
  endtask
  task automatic rand_fp(input int len);
    fp.delete();
    for (int i = 0; i < len; i++) fp.push_back(8'($urandom_range(0, 255)));
  endtask
  task automatic badlen(input logic [7:0] l);
    preamble($urandom_range(0, 2), 1'b0);
    evq.push_back('{1'b0, 2'b10, 0});
    send(l);
    step(3);
    chk("state_after_badlen", o_state, 3'd0);
  endtask
  initial begin
    logic [7:0] c;
    step(2);
    chk("rst_count", o_count, 0);
    chk("rst_empty", o_empty, 1);
    chk("rst_pulses", {o_frame_done, o_frame_err}, 0);
    chk("rst_code", o_err_code, 0);
    chk("rst_fc", o_frame_count, 0);
    chk("rst_state", o_state, 0);
    RESET = 1'b1;
    step(2);
    hold_fix = 7;
    fp = '{8'h11, 8'h22, 8'h33};
    frame(1'b1, 0, 1'b0);
    rd(3);
    hold_fix = 0;
    fp = '{8'hAA, 8'h55};
    frame(1'b0, 0, 1'b0);
    rand_fp(5);
    frame(1'b1, 1, 1'b0);
    fp.delete();
    frame(1'b1, 0, 1'b1);
    badlen(8'h21);
    rd(mcount);
    step(2);
    rand_fp(32);
    frame(1'b1, 0, 1'b0);
    rand_fp(32);
    frame(1'b1, 0, 1'b0);
    rand_fp(5);
    frame(1'b1, 0, 1'b0);
    rd(1);
    frame(1'b1, 0, 1'b0);
    rd(63);
    frame(1'b1, 0, 1'b0);
    // a strobe seen with EN low must not enter the frame
    fp = '{8'hAA, 8'hBB};
    evq.push_back('{1'b1, 2'b00, 2});
    foreach (fp[i]) pay_q.push_back(fp[i]);
    mcount += 2;
    preamble(0, 1'b0);
    send(8'h02);
    EN = 1'b0;
    send(8'h77);
    EN = 1'b1;
    send(8'hAA);
    send(8'hBB);
    send(8'h02 ^ 8'hAA ^ 8'hBB);
    step(3);
    // commit and read landing on the same edge
    rand_fp(3);
    c = 8'h03 ^ fp[0] ^ fp[1] ^ fp[2];
    evq.push_back('{1'b1, 2'b00, 3});
    foreach (fp[i]) pay_q.push_back(fp[i]);
    preamble(0, 1'b0);
    send(8'h03);
    foreach (fp[i]) send(fp[i]);
    fork
      send(c);
      rd(3);
    join
    mcount += 3;
    step(3);
    preamble(0, 1'b0);
    send(8'h0A);
    send(8'h01);
    send(8'h02);
    @(posedge i_Clock);
    #3 RESET = 1'b0;
    #1;
    chk("mid_rst_count", o_count, 0);
    chk("mid_rst_empty", o_empty, 1);
    chk("mid_rst_pulses", {o_frame_done, o_frame_err}, 0);
    chk("mid_rst_code", o_err_code, 0);
    chk("mid_rst_fc", o_frame_count, 0);
    chk("mid_rst_state", o_state, 0);
    i_save_byte = 1'b0;
    evq.delete();
    pay_q.delete();
    data_q.delete();
    exp_fc = '0;
    mcount = 0;
    step(2);
    @(posedge i_Clock);
    #3 RESET = 1'b1;
    step(2);
    rand_fp(4);
    frame(1'b1, 0, 1'b0);
    for (int k = 0; k < 60; k++) begin
      int t = $urandom_range(0, 9);
      if (t <= 5) begin
        rand_fp($urandom_range(0, 32));
        frame(1'b1, $urandom_range(0, 2), $urandom_range(0, 3) == 0);
      end else if (t <= 7) begin
        rand_fp($urandom_range(0, 32));
        frame(1'b0, $urandom_range(0, 2), 1'b0);
      end else if (t == 8) badlen(8'($urandom_range(33, 255)));
      else rd($urandom_range(0, mcount));
    end
    rd(mcount);
    step(3);
    for (int t = 0; t < 200 && evq.size() != 0; t++) step(1);
    chk("events_drained", evq.size(), 0);
    chk("data_drained", data_q.size(), 0);
    chk("final_state", o_state, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
